ram_write_arbiter: RTL and testbench

RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 18 +
 rtl/ram_write_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_write_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-requester RAM write
// arbiter.
//   ADDR_W  - RAM address width (fixed at 2)
//   DEPTH   - number of RAM entries (fixed at 4)
//   state_t - arbiter state: INIT (post-reset clear) or RUN
//   grant_t - 2-bit one-hot requester grant ({req1, req0}), 0 = none
package ram_arb_pkg;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  typedef enum logic {INIT, RUN} state_t;
  typedef logic [1:0] grant_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector, purely combinational.
//   valid - {req1, req0} pending requests
//   ptr   - requester favoured on contention (0 = req0, 1 = req1)
//   grant - one-hot winner, 0 when nothing is valid
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output grant_t     grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: merges two write requesters onto one RAM write port.
// One request is accepted per cycle (VALID & READY); the accepted write
// appears on WE/WADDR/WDATA/GRANT one cycle later from registers.
// Contention is resolved round-robin, requester 0 first after reset.
//   CLK, RESETN               - clock, async active-low reset
//   REQx_VALID/ADDR/DATA      - requester x write request
//   REQx_READY                - requester x accepted this cycle
//   WADDR, WDATA, WE          - RAM write port
//   GRANT                     - one-hot owner of the current WE cycle
//   BUSY                      - post-reset clear in progress
// Build option: RAM_ARB_INIT_EN adds an INIT phase that writes 0 to every
// entry after reset before requests are accepted. Without it the block is
// in RUN straight out of reset and BUSY is tied 0.
module ram_write_arbiter #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             REQ0_VALID,
  input  logic [1:0]       REQ0_ADDR,
  input  logic [WIDTH-1:0] REQ0_DATA,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [1:0]       REQ1_ADDR,
  input  logic [WIDTH-1:0] REQ1_DATA,
  output logic             REQ1_READY,
  output logic [1:0]       WADDR,
  output logic [WIDTH-1:0] WDATA,
  output logic             WE,
  output logic [1:0]       GRANT,
  output logic             BUSY
);
  import ram_arb_pkg::*;

  // Address width is fixed, so only a 4-entry RAM can be cleared correctly.
  if (DEPTH != 4) begin : g_depth_chk
    $error("ram_write_arbiter: DEPTH must be 4");
  end

  grant_t             arb_gnt, acc;
  state_t             state_q;
  logic               prio_q, prio_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  grant_t             grant_q, grant_d;

  rr_arb2 u_rr (
    .valid ({REQ1_VALID, REQ0_VALID}),
    .ptr   (prio_q),
    .grant (arb_gnt)
  );

  // READY is gated by RESETN directly so it drops the instant reset asserts,
  // even in the build where the state is permanently RUN.
  assign acc        = (RESETN && state_q == RUN) ? arb_gnt : 2'b00;
  assign REQ0_READY = acc[0];
  assign REQ1_READY = acc[1];

`ifdef RAM_ARB_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY = (state_q == INIT);
`else
  assign state_q = RUN;
  assign BUSY    = 1'b0;
`endif

  always_comb begin
    prio_d  = prio_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    grant_d = acc;
    if (acc[1]) begin
      we_d    = 1'b1;
      waddr_d = REQ1_ADDR;
      wdata_d = REQ1_DATA;
      prio_d  = 1'b0;
    end else if (acc[0]) begin
      we_d    = 1'b1;
      waddr_d = REQ0_ADDR;
      wdata_d = REQ0_DATA;
      prio_d  = 1'b1;
    end
`ifdef RAM_ARB_INIT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    // acc is 0 in INIT, so the clear write never collides with a request.
    if (state_q == INIT) begin
      we_d    = 1'b1;
      waddr_d = cnt_q;
      wdata_d = '0;
      cnt_d   = cnt_q + 2'd1;  // wraps 3 -> 0 on the exit to RUN
      if (cnt_q == LAST_ADDR) state_d = RUN;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      grant_q <= '0;
    end else begin
      prio_q  <= prio_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
    end
  end

  assign WE    = we_q;
  assign WADDR = waddr_q;
  assign WDATA = wdata_q;
  assign GRANT = grant_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Scoreboarded bench for ram_write_arbiter (WIDTH=1). Directed vectors push
// the expected write into a queue; a negedge monitor pops and compares on
// every WE cycle and mirrors the writes into a small RAM image.
// Works in both builds (with or without RAM_ARB_INIT_EN).
module tb_ram_write_arbiter;

  logic       CLK, RESETN;
  logic       REQ0_VALID, REQ0_DATA, REQ0_READY;
  logic [1:0] REQ0_ADDR;
  logic       REQ1_VALID, REQ1_DATA, REQ1_READY;
  logic [1:0] REQ1_ADDR;
  logic [1:0] WADDR, GRANT;
  logic       WDATA, WE, BUSY;

  typedef struct {
    logic [1:0] addr;
    logic       data;
    logic [1:0] gnt;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  logic ram_m [4];
  int   n_chk = 0;
  int   n_err = 0;

  ram_write_arbiter #(.WIDTH(1), .DEPTH(4)) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_ADDR  (REQ0_ADDR),
    .REQ0_DATA  (REQ0_DATA),
    .REQ0_READY (REQ0_READY),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_ADDR  (REQ1_ADDR),
    .REQ1_DATA  (REQ1_DATA),
    .REQ1_READY (REQ1_READY),
    .WADDR      (WADDR),
    .WDATA      (WDATA),
    .WE         (WE),
    .GRANT      (GRANT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every WE cycle must match the oldest expected write.
  always @(negedge CLK) begin
    if (RESETN === 1'b1) begin
      if (WE === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("waddr", WADDR, mon_e.addr);
          chk("wdata", WDATA, mon_e.data);
          chk("grant", GRANT, mon_e.gnt);
          ram_m[WADDR] = WDATA;
        end
      end else begin
        chk("grant_idle", GRANT, 0);
      end
    end
  end

  // One request cycle with hand-computed expected READY {req1, req0}.
  task automatic cyc(input logic v0, input logic [1:0] a0, input logic d0,
                     input logic v1, input logic [1:0] a1, input logic d1,
                     input logic [1:0] eg);
    REQ0_VALID = v0; REQ0_ADDR = a0; REQ0_DATA = d0;
    REQ1_VALID = v1; REQ1_ADDR = a1; REQ1_DATA = d1;
    @(negedge CLK);
    chk("ready", {REQ1_READY, REQ0_READY}, eg);
    chk("busy_run", BUSY, 0);
    if (eg == 2'b01)      exp_q.push_back('{a0, d0, 2'b01});
    else if (eg == 2'b10) exp_q.push_back('{a1, d1, 2'b10});
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
  endtask

  // Assert reset wherever we are, check the forced outputs, release
  // just after a rising edge, then (with the clear sequence) check INIT.
  task automatic do_reset();
    #1 RESETN = 1'b0;
    #1;
    chk("rst_we",    WE, 0);
    chk("rst_waddr", WADDR, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_grant", GRANT, 0);
    chk("rst_ready", {REQ1_READY, REQ0_READY}, 0);
`ifdef RAM_ARB_INIT_EN
    chk("rst_busy", BUSY, 1);
`else
    chk("rst_busy", BUSY, 0);
`endif
    exp_q.delete();
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;
`ifdef RAM_ARB_INIT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back('{2'(i), 1'b0, 2'b00});
    REQ0_VALID = 1'b1;
    REQ0_ADDR  = 2'd0;
    REQ0_DATA  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("init_busy", BUSY, 1);
      chk("init_ready", {REQ1_READY, REQ0_READY}, 0);
      @(posedge CLK); #1;
    end
    REQ0_VALID = 1'b0;
`endif
  endtask

  initial begin
    RESETN = 1'b0;
    REQ0_VALID = 1'b0; REQ0_ADDR = 2'd0; REQ0_DATA = 1'b0;
    REQ1_VALID = 1'b0; REQ1_ADDR = 2'd0; REQ1_DATA = 1'b0;
    do_reset();

    // Lone requester 0 accepted immediately; write lands next cycle.
    cyc(1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01);
    idle();

    // Fresh reset: both held 4 cycles -> strict alternation starting at req0.
    do_reset();
    cyc(1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'b01);
    cyc(1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'b10);
    cyc(1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'b01);
    cyc(1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 2'b10);
    idle();

    // Same address back to back: later grant (req1, data 1) wins.
    cyc(1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b1, 2'b01);
    cyc(1'b0, 2'd3, 1'b0, 1'b1, 2'd3, 1'b1, 2'b10);
    idle();
    chk("ram3_last_wins", ram_m[3], 1);

    // Lone req1 while the pointer favours req0 is still granted.
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 2'b10);
    // Pointer moved back to req0 after that grant.
    cyc(1'b1, 2'd1, 1'b0, 1'b1, 2'd0, 1'b1, 2'b01);
    idle();
    chk("ram1_pre", ram_m[1], 0);

    // Accept a write to entry 1, then reset before it can be issued.
    REQ0_VALID = 1'b1; REQ0_ADDR = 2'd1; REQ0_DATA = 1'b1;
    REQ1_VALID = 1'b0;
    @(negedge CLK);
    chk("inflight_ready", REQ0_READY, 1);
    do_reset();
    idle();
    idle();
    chk("inflight_dropped", ram_m[1], 0);

    // Normal operation after the mid-flight reset.
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01);
    idle();
    chk("ram0_after_rst", ram_m[0], 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
